// File: rtl/router_in_port.sv
`timescale 1ns/1ps
// router_in_port
// Router-side receive port for one node link. Reassembles the 4-byte serial
// packet stream from a node into 32-bit packets, buffers up to DEPTH of them
// and presents the head packet with a one-hot output-port request.
//
// Parameters:
//   ROUTERID        2-bit id of this router, matched against dest[3:2]
//   DEPTH           packet buffer entries (power of 2, >= 2)
// Ports:
//   clock           rising-edge clock
//   reset_n         asynchronous active-low reset
//   put_inbound     node presents a payload byte this cycle
//   payload_inbound byte from the node
//   free_inbound    registered; a whole packet can be accepted
//   pkt_valid       head packet available
//   pkt_head        head packet {src, dest, data[23:0]}
//   out_port_req    one-hot route of the head packet, zero when empty
//   grant           crossbar takes the head packet at this edge
//   occupancy       packets currently buffered
//   drop_cnt        saturating count of aborted / unsolicited packets
module router_in_port #(
   parameter logic [1:0]  ROUTERID = 2'd0,
   parameter int unsigned DEPTH    = 4
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     put_inbound,
   input  logic [7:0]               payload_inbound,
   output logic                     free_inbound,
   output logic                     pkt_valid,
   output logic [31:0]              pkt_head,
   output logic [4:0]               out_port_req,
   input  logic                     grant,
   output logic [$clog2(DEPTH):0]   occupancy,
   output logic [7:0]               drop_cnt
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_B1   = 2'd1;
   localparam logic [1:0] S_B2   = 2'd2;
   localparam logic [1:0] S_B3   = 2'd3;

   logic [1:0]    state, next_state;
   logic [7:0]    hdr, b1, b2;
   logic [31:0]   q [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   occ_next;
   logic          wr_en, pop, drop_ev, accept_hdr;
   logic [3:0]    dest;

   assign accept_hdr = (state == S_IDLE) && put_inbound && free_inbound;
   assign wr_en      = (state == S_B3) && put_inbound;
   assign pop        = grant && pkt_valid;
   // A gap inside a packet aborts it; a byte offered while not free is refused.
   assign drop_ev    = ((state != S_IDLE) && !put_inbound) ||
                       ((state == S_IDLE) && put_inbound && !free_inbound);

   always_comb begin
      next_state = S_IDLE;
      case (state)
         S_IDLE: next_state = accept_hdr  ? S_B1 : S_IDLE;
         S_B1:   next_state = put_inbound ? S_B2 : S_IDLE;
         S_B2:   next_state = put_inbound ? S_B3 : S_IDLE;
         default: next_state = S_IDLE;
      endcase
   end

   always_comb begin
      occ_next = occupancy;
      if (wr_en && !pop)
         occ_next = occupancy + 1'b1;
      else if (pop && !wr_en)
         occ_next = occupancy - 1'b1;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state        <= S_IDLE;
         hdr          <= '0;
         b1           <= '0;
         b2           <= '0;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         occupancy    <= '0;
         drop_cnt     <= '0;
         free_inbound <= 1'b0;
         for (int unsigned i = 0; i < DEPTH; i++)
            q[i] <= '0;
      end else begin
         state     <= next_state;
         occupancy <= occ_next;
         // Free only when the next packet is guaranteed a slot, so the
         // B3 write can never meet a full buffer.
         free_inbound <= (next_state == S_IDLE) && (occ_next < DEPTH_L);
         if (accept_hdr)
            hdr <= payload_inbound;
         if (state == S_B1 && put_inbound)
            b1 <= payload_inbound;
         if (state == S_B2 && put_inbound)
            b2 <= payload_inbound;
         if (wr_en) begin
            q[wr_ptr] <= {hdr, b1, b2, payload_inbound};
            wr_ptr    <= wr_ptr + 1'b1;
         end
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         if (drop_ev && drop_cnt != 8'hFF)
            drop_cnt <= drop_cnt + 8'd1;
      end
   end

   assign pkt_valid = (occupancy != '0);
   assign pkt_head  = q[rd_ptr];
   assign dest      = pkt_head[27:24];

   always_comb begin
      out_port_req = '0;
      if (pkt_valid) begin
         if (dest[3:2] == ROUTERID)
            out_port_req = 5'b00001 << dest[1:0];
         else
            out_port_req = 5'b10000;
      end
   end

endmodule

// File: tb/tb_router_in_port.sv
`timescale 1ns/1ps
// Directed testbench for router_in_port (ROUTERID=1, DEPTH=4).
module tb_router_in_port;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        put_inbound = 1'b0;
   logic [7:0]  payload_inbound = '0;
   logic        grant = 1'b0;
   logic        free_inbound;
   logic        pkt_valid;
   logic [31:0] pkt_head;
   logic [4:0]  out_port_req;
   logic [2:0]  occupancy;
   logic [7:0]  drop_cnt;

   int vectors = 0;
   int miscompares = 0;

   router_in_port #(.ROUTERID(2'd1), .DEPTH(4)) dut (
      .clock(clock), .reset_n(reset_n),
      .put_inbound(put_inbound), .payload_inbound(payload_inbound),
      .free_inbound(free_inbound), .pkt_valid(pkt_valid),
      .pkt_head(pkt_head), .out_port_req(out_port_req),
      .grant(grant), .occupancy(occupancy), .drop_cnt(drop_cnt)
   );

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time exhausted, required $finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic wait_free();
      int n = 0;
      while (free_inbound !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      vectors++;
      if (free_inbound !== 1'b1) begin
         miscompares++;
         $display("FAIL wait_free: free_inbound=%b required 1 within 20 cycles", free_inbound);
      end
   endtask

   task automatic send_pkt(input logic [31:0] p, input logic g_last);
      wait_free();
      for (int i = 0; i < 4; i++) begin
         put_inbound     = 1'b1;
         payload_inbound = p[31-8*i -: 8];
         grant           = g_last && (i == 3);
         tick();
      end
      put_inbound = 1'b0;
      grant       = 1'b0;
   endtask

   task automatic do_grant();
      grant = 1'b1;
      tick();
      grant = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      vectors++;
      if ({free_inbound, pkt_valid, pkt_head, out_port_req, occupancy, drop_cnt} !== 50'h0) begin
         miscompares++;
         $display("FAIL rst_outputs: got free=%b valid=%b head=%h req=%b occ=%0d drop=%0d required all 0",
                  free_inbound, pkt_valid, pkt_head, out_port_req, occupancy, drop_cnt);
      end
      tick();
      reset_n = 1'b1;
      #2;
      vectors++;
      if (free_inbound !== 1'b0) begin
         miscompares++;
         $display("FAIL rst_free_before_edge: got %b required 0", free_inbound);
      end
      tick();
      vectors++;
      if (free_inbound !== 1'b1 || occupancy !== 3'd0) begin
         miscompares++;
         $display("FAIL rst_release: got free=%b occ=%0d required free=1 occ=0", free_inbound, occupancy);
      end
      // Two bytes of a packet (FSM in B2), then reset mid-packet.
      put_inbound = 1'b1; payload_inbound = 8'h36; tick();
      payload_inbound = 8'h11; tick();
      reset_n = 1'b0;
      #1;
      put_inbound = 1'b0;
      vectors++;
      if ({free_inbound, pkt_valid, pkt_head, out_port_req, occupancy, drop_cnt} !== 50'h0) begin
         miscompares++;
         $display("FAIL rst_mid_b2: got free=%b valid=%b head=%h req=%b occ=%0d drop=%0d required all 0",
                  free_inbound, pkt_valid, pkt_head, out_port_req, occupancy, drop_cnt);
      end
      tick();
      reset_n = 1'b1;
      tick();
      tick();
      tick();
      vectors++;
      if (free_inbound !== 1'b1 || occupancy !== 3'd0 || pkt_valid !== 1'b0 || drop_cnt !== 8'd0) begin
         miscompares++;
         $display("FAIL rst_partial_gone: got free=%b occ=%0d valid=%b drop=%0d required 1,0,0,0",
                  free_inbound, occupancy, pkt_valid, drop_cnt);
      end
   endtask

   task automatic test_single();
      wait_free();
      put_inbound = 1'b1;
      payload_inbound = 8'h36; tick();
      payload_inbound = 8'hAB; tick();
      payload_inbound = 8'hCD; tick();
      payload_inbound = 8'hEF;
      vectors++;
      if (pkt_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL single_early_valid: got %b required 0 while last byte presented", pkt_valid);
      end
      tick();
      put_inbound = 1'b0;
      vectors++;
      if (pkt_valid !== 1'b1 || pkt_head !== 32'h36ABCDEF) begin
         miscompares++;
         $display("FAIL single_head: got valid=%b head=%h required 1 36abcdef", pkt_valid, pkt_head);
      end
      vectors++;
      if (out_port_req !== 5'b00100 || occupancy !== 3'd1) begin
         miscompares++;
         $display("FAIL single_route: got req=%b occ=%0d required 00100 1", out_port_req, occupancy);
      end
      do_grant();
      vectors++;
      if (pkt_valid !== 1'b0 || out_port_req !== 5'b00000 || occupancy !== 3'd0) begin
         miscompares++;
         $display("FAIL single_pop: got valid=%b req=%b occ=%0d required 0 00000 0",
                  pkt_valid, out_port_req, occupancy);
      end
   endtask

   task automatic test_uplink();
      send_pkt(32'h2B123456, 1'b0);
      vectors++;
      if (out_port_req !== 5'b10000 || pkt_head !== 32'h2B123456) begin
         miscompares++;
         $display("FAIL uplink_route: got req=%b head=%h required 10000 2b123456", out_port_req, pkt_head);
      end
      do_grant();
      // Grant while empty changes nothing.
      do_grant();
      vectors++;
      if (occupancy !== 3'd0 || pkt_valid !== 1'b0 || drop_cnt !== 8'd0 || free_inbound !== 1'b1) begin
         miscompares++;
         $display("FAIL empty_grant: got occ=%0d valid=%b drop=%0d free=%b required 0 0 0 1",
                  occupancy, pkt_valid, drop_cnt, free_inbound);
      end
   endtask

   task automatic test_fill();
      logic [31:0] exp_q [4];
      for (int i = 0; i < 4; i++) begin
         send_pkt(32'h05000000 + 32'(i), 1'b0);
      end
      vectors++;
      if (occupancy !== 3'd4 || free_inbound !== 1'b0) begin
         miscompares++;
         $display("FAIL fill_full: got occ=%0d free=%b required 4 0", occupancy, free_inbound);
      end
      vectors++;
      if (pkt_head !== 32'h05000000 || out_port_req !== 5'b00010) begin
         miscompares++;
         $display("FAIL fill_head: got head=%h req=%b required 05000000 00010", pkt_head, out_port_req);
      end
      put_inbound = 1'b1; payload_inbound = 8'h77; tick();
      put_inbound = 1'b0;
      tick();
      vectors++;
      if (drop_cnt !== 8'd1 || occupancy !== 3'd4) begin
         miscompares++;
         $display("FAIL fill_extra_put: got drop=%0d occ=%0d required 1 4", drop_cnt, occupancy);
      end
      do_grant();
      vectors++;
      if (free_inbound !== 1'b1 || occupancy !== 3'd3 || pkt_head !== 32'h05000001) begin
         miscompares++;
         $display("FAIL fill_regrant: got free=%b occ=%0d head=%h required 1 3 05000001",
                  free_inbound, occupancy, pkt_head);
      end
      // Write and pop at the same edge with occupancy DEPTH-1.
      send_pkt(32'h05000004, 1'b1);
      vectors++;
      if (occupancy !== 3'd3 || free_inbound !== 1'b1) begin
         miscompares++;
         $display("FAIL simul_wr_pop: got occ=%0d free=%b required 3 1", occupancy, free_inbound);
      end
      exp_q[0] = 32'h05000002; exp_q[1] = 32'h05000003; exp_q[2] = 32'h05000004;
      for (int i = 0; i < 3; i++) begin
         vectors++;
         if (pkt_head !== exp_q[i] || pkt_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL drain_order[%0d]: got head=%h valid=%b required %h 1", i, pkt_head, pkt_valid, exp_q[i]);
         end
         do_grant();
      end
      vectors++;
      if (occupancy !== 3'd0 || pkt_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL drain_empty: got occ=%0d valid=%b required 0 0", occupancy, pkt_valid);
      end
   endtask

   task automatic test_abort();
      wait_free();
      put_inbound = 1'b1;
      payload_inbound = 8'h36; tick();
      payload_inbound = 8'h99; tick();
      put_inbound = 1'b0; tick();
      vectors++;
      if (drop_cnt !== 8'd2 || occupancy !== 3'd0 || free_inbound !== 1'b1 || pkt_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL abort: got drop=%0d occ=%0d free=%b valid=%b required 2 0 1 0",
                  drop_cnt, occupancy, free_inbound, pkt_valid);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] p;
      for (int k = 0; k < 10; k++) begin
         p = 32'h34000000 | 32'(k);
         send_pkt(p, 1'b1);
         vectors++;
         if (pkt_head !== p || occupancy !== 3'd1 || out_port_req !== 5'b00001) begin
            miscompares++;
            $display("FAIL wrap[%0d]: got head=%h occ=%0d req=%b required %h 1 00001",
                     k, pkt_head, occupancy, out_port_req, p);
         end
      end
      do_grant();
      vectors++;
      if (occupancy !== 3'd0 || pkt_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL wrap_empty: got occ=%0d valid=%b required 0 0", occupancy, pkt_valid);
      end
   endtask

   task automatic test_drop_saturate();
      for (int a = 0; a < 300; a++) begin
         wait_free();
         for (int b = 0; b < (a % 3) + 1; b++) begin
            put_inbound = 1'b1;
            payload_inbound = 8'(a);
            tick();
         end
         put_inbound = 1'b0;
         tick();
         if (a == 9) begin
            vectors++;
            if (drop_cnt !== 8'd12) begin
               miscompares++;
               $display("FAIL drop_count_mid: got %0d required 12", drop_cnt);
            end
         end
      end
      vectors++;
      if (drop_cnt !== 8'hFF || occupancy !== 3'd0) begin
         miscompares++;
         $display("FAIL drop_saturate: got drop=%h occ=%0d required ff 0", drop_cnt, occupancy);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_uplink();
      test_fill();
      test_abort();
      test_back_to_back();
      test_drop_saturate();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
